// File: rtl/counter_pkg.sv
// counter_pkg: shared types and helpers for the saturating/wrapping counter
// family (single counter_sat today, multi-channel counter bank later).
//   cnt_mode_e : counter overflow policy, encoded to match the sat_mode pin
//   safe_clog2 : ceil(log2(v)) that never returns 0, so it can size a vector
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    // Width needed to index v distinct values; clamps to 1 so a degenerate
    // single-value range still yields a legal vector width.
    function automatic int safe_clog2(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/counter_sat_next.sv
// counter_sat_next: purely combinational next-count calculation.
// Applies an optional increment and decrement to a base count and folds the
// result back into [0, MAX_VALUE] by either wrapping or saturating.
// Ports:
//   base        in  WIDTH       current (or reinit) count, already <= MAX_VALUE
//   incr_valid  in  1           qualifies incr
//   incr        in  INCR_WIDTH  unsigned increment
//   decr_valid  in  1           qualifies decr
//   decr        in  DECR_WIDTH  unsigned decrement
//   mode        in  cnt_mode_e  CNT_WRAP or CNT_SAT
//   value_next  out WIDTH       folded result
//   ovf         out 1           raw sum exceeded MAX_VALUE
//   udf         out 1           raw sum went below zero
module counter_sat_next
    import counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int INCR_WIDTH = 2,
    parameter int DECR_WIDTH = 2,
    parameter int MAX_VALUE  = 2**WIDTH - 1
) (
    input  logic [WIDTH-1:0]      base,
    input  logic                  incr_valid,
    input  logic [INCR_WIDTH-1:0] incr,
    input  logic                  decr_valid,
    input  logic [DECR_WIDTH-1:0] decr,
    input  cnt_mode_e             mode,
    output logic [WIDTH-1:0]      value_next,
    output logic                  ovf,
    output logic                  udf
);

    // Two guard bits: one for carry above 2**WIDTH-1, one for sign.
    localparam int SW = WIDTH + 2;
    localparam logic signed [SW-1:0] MAX_S = SW'(MAX_VALUE);
    localparam logic signed [SW-1:0] MOD_S = SW'(MAX_VALUE + 1);

    if (MAX_VALUE > 2**WIDTH - 1) begin : g_bad_max
        $error("counter_sat_next: MAX_VALUE does not fit in WIDTH bits");
    end
    if (2**INCR_WIDTH - 1 > MAX_VALUE + 1) begin : g_bad_incr
        $error("counter_sat_next: INCR_WIDTH allows a step larger than the modulus");
    end
    if (2**DECR_WIDTH - 1 > MAX_VALUE + 1) begin : g_bad_decr
        $error("counter_sat_next: DECR_WIDTH allows a step larger than the modulus");
    end

    // Bring an out-of-range raw sum back into [0, MAX_VALUE]. Because a single
    // step never exceeds the modulus, one add/subtract of MOD_S is enough.
    function automatic logic signed [SW-1:0] fold(
        input logic signed [SW-1:0] raw,
        input cnt_mode_e            md
    );
        if (raw[SW-1]) begin
            return (md == CNT_SAT) ? '0 : raw + MOD_S;
        end else if (raw > MAX_S) begin
            return (md == CNT_SAT) ? MAX_S : raw - MOD_S;
        end
        return raw;
    endfunction

    logic signed [SW-1:0] inc_s;
    logic signed [SW-1:0] dec_s;
    logic signed [SW-1:0] raw_s;

    always_comb begin
        inc_s = '0;
        dec_s = '0;
        if (incr_valid) inc_s = SW'(incr);
        if (decr_valid) dec_s = SW'(decr);
        raw_s      = $signed({2'b00, base}) + inc_s - dec_s;
        ovf        = raw_s > MAX_S;
        udf        = raw_s[SW-1];
        value_next = WIDTH'(fold(raw_s, mode));
    end

endmodule

// File: rtl/counter_sat.sv
// counter_sat: parametrised up/down counter with wrap or saturate policy.
// Holds the count register, single-cycle overflow/underflow pulses, sticky
// event flags and a registered threshold compare. Next-count arithmetic lives
// in counter_sat_next so a multi-channel bank can share it.
// Ports:
//   clk, rst_n      clock; synchronous active-low reset (loads initial_value)
//   reinit          use initial_value instead of value as the base this cycle
//   initial_value   reset/reinit load value, clamped to MAX_VALUE
//   incr_valid/incr optional unsigned increment
//   decr_valid/decr optional unsigned decrement
//   sat_mode        1 = saturate at 0/MAX_VALUE, 0 = wrap modulo MAX_VALUE+1
//   clear_flags     clears sticky flags (a same-cycle event still wins)
//   threshold       compare level for ge_thresh
//   value           registered count
//   value_next      combinational look-ahead of the next count
//   ovf_pulse/udf_pulse    one cycle high after an overflow/underflow update
//   ovf_sticky/udf_sticky  latched events, held until clear_flags
//   at_zero/at_max         decodes of value
//   ge_thresh       registered value_next >= threshold, aligned with value
module counter_sat
    import counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int INCR_WIDTH = 2,
    parameter int DECR_WIDTH = 2,
    parameter int MAX_VALUE  = 2**WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reinit,
    input  logic [WIDTH-1:0]      initial_value,
    input  logic                  incr_valid,
    input  logic [INCR_WIDTH-1:0] incr,
    input  logic                  decr_valid,
    input  logic [DECR_WIDTH-1:0] decr,
    input  logic                  sat_mode,
    input  logic                  clear_flags,
    input  logic [WIDTH-1:0]      threshold,
    output logic [WIDTH-1:0]      value,
    output logic [WIDTH-1:0]      value_next,
    output logic                  ovf_pulse,
    output logic                  udf_pulse,
    output logic                  ovf_sticky,
    output logic                  udf_sticky,
    output logic                  at_zero,
    output logic                  at_max,
    output logic                  ge_thresh
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VALUE);

    logic [WIDTH-1:0] init_clamped;
    logic [WIDTH-1:0] base;
    logic             ovf;
    logic             udf;

    // The load value is clamped so the register can never hold an illegal
    // count; the load itself therefore never looks like an overflow.
    assign init_clamped = (initial_value > MAX_W) ? MAX_W : initial_value;
    assign base         = reinit ? init_clamped : value;

    counter_sat_next #(
        .WIDTH      (WIDTH),
        .INCR_WIDTH (INCR_WIDTH),
        .DECR_WIDTH (DECR_WIDTH),
        .MAX_VALUE  (MAX_VALUE)
    ) u_next (
        .base       (base),
        .incr_valid (incr_valid),
        .incr       (incr),
        .decr_valid (decr_valid),
        .decr       (decr),
        .mode       (cnt_mode_e'(sat_mode)),
        .value_next (value_next),
        .ovf        (ovf),
        .udf        (udf)
    );

    // Register stage: count, event pulses, sticky flags and threshold compare.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value      <= init_clamped;
            ovf_pulse  <= 1'b0;
            udf_pulse  <= 1'b0;
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
            ge_thresh  <= init_clamped >= threshold;
        end else begin
            value      <= value_next;
            ovf_pulse  <= ovf;
            udf_pulse  <= udf;
            // A new event in the same cycle as clear_flags keeps the flag set.
            ovf_sticky <= (ovf_sticky & ~clear_flags) | ovf;
            udf_sticky <= (udf_sticky & ~clear_flags) | udf;
            ge_thresh  <= value_next >= threshold;
        end
    end

    assign at_zero = (value == '0);
    assign at_max  = (value == MAX_W);

endmodule

// File: tb/tb_counter_sat.sv
module tb_counter_sat;

    localparam int W    = 4;
    localparam int MAXV = 9;

    logic         clk;
    logic         rst_n;
    logic         reinit;
    logic [W-1:0] initial_value;
    logic         incr_valid;
    logic [1:0]   incr;
    logic         decr_valid;
    logic [1:0]   decr;
    logic         sat_mode;
    logic         clear_flags;
    logic [W-1:0] threshold;
    logic [W-1:0] value;
    logic [W-1:0] value_next;
    logic         ovf_pulse;
    logic         udf_pulse;
    logic         ovf_sticky;
    logic         udf_sticky;
    logic         at_zero;
    logic         at_max;
    logic         ge_thresh;

    counter_sat #(
        .WIDTH      (W),
        .INCR_WIDTH (2),
        .DECR_WIDTH (2),
        .MAX_VALUE  (MAXV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .reinit        (reinit),
        .initial_value (initial_value),
        .incr_valid    (incr_valid),
        .incr          (incr),
        .decr_valid    (decr_valid),
        .decr          (decr),
        .sat_mode      (sat_mode),
        .clear_flags   (clear_flags),
        .threshold     (threshold),
        .value         (value),
        .value_next    (value_next),
        .ovf_pulse     (ovf_pulse),
        .udf_pulse     (udf_pulse),
        .ovf_sticky    (ovf_sticky),
        .udf_sticky    (udf_sticky),
        .at_zero       (at_zero),
        .at_max        (at_max),
        .ge_thresh     (ge_thresh)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int rst_n, reinit, iv, incr, dv, decr, sat, clr, init, thr;
        int e_val, e_op, e_up, e_os, e_us, e_ge;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state (plain integers).
    int m_val = 0, m_ovp = 0, m_udp = 0, m_ovs = 0, m_uds = 0, m_ge = 0;

    function automatic vec_t mk(int rst_n_i, int reinit_i, int iv_i, int incr_i,
                                int dv_i, int decr_i, int sat_i, int clr_i,
                                int init_i, int thr_i, int e_val_i, int e_op_i,
                                int e_up_i, int e_os_i, int e_us_i, int e_ge_i);
        vec_t v;
        v.rst_n = rst_n_i; v.reinit = reinit_i; v.iv = iv_i; v.incr = incr_i;
        v.dv = dv_i; v.decr = decr_i; v.sat = sat_i; v.clr = clr_i;
        v.init = init_i; v.thr = thr_i;
        v.e_val = e_val_i; v.e_op = e_op_i; v.e_up = e_up_i;
        v.e_os = e_os_i; v.e_us = e_us_i; v.e_ge = e_ge_i;
        return v;
    endfunction

    // Next count from the arithmetic rules: clamp the load, add/subtract the
    // deltas as integers, then wrap by the modulus or clamp to the range.
    function automatic void model_comb(input vec_t v, input int cur,
                                       output int nxt, output int ov, output int un);
        int b, raw;
        b   = v.reinit != 0 ? ((v.init > MAXV) ? MAXV : v.init) : cur;
        raw = b + (v.iv != 0 ? v.incr : 0) - (v.dv != 0 ? v.decr : 0);
        ov  = (raw > MAXV) ? 1 : 0;
        un  = (raw < 0) ? 1 : 0;
        if (v.sat != 0) nxt = (raw > MAXV) ? MAXV : ((raw < 0) ? 0 : raw);
        else            nxt = (raw + (MAXV + 1)) % (MAXV + 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Drive one cycle starting from a falling edge; checks the look-ahead
    // before the rising edge, advances the model, and returns at the next
    // falling edge.
    task automatic apply(input vec_t v, input string tag);
        int nx, ov, un;
        rst_n         = v.rst_n[0];
        reinit        = v.reinit[0];
        initial_value = W'(v.init);
        incr_valid    = v.iv[0];
        incr          = 2'(v.incr);
        decr_valid    = v.dv[0];
        decr          = 2'(v.decr);
        sat_mode      = v.sat[0];
        clear_flags   = v.clr[0];
        threshold     = W'(v.thr);
        #1;
        model_comb(v, m_val, nx, ov, un);
        chk({tag, " value_next"}, int'(value_next), nx);
        @(posedge clk);
        if (v.rst_n == 0) begin
            m_val = (v.init > MAXV) ? MAXV : v.init;
            m_ovp = 0; m_udp = 0; m_ovs = 0; m_uds = 0;
            m_ge  = (m_val >= v.thr) ? 1 : 0;
        end else begin
            m_val = nx;
            m_ovp = ov;
            m_udp = un;
            m_ovs = ((m_ovs != 0 && v.clr == 0) || ov != 0) ? 1 : 0;
            m_uds = ((m_uds != 0 && v.clr == 0) || un != 0) ? 1 : 0;
            m_ge  = (nx >= v.thr) ? 1 : 0;
        end
        @(negedge clk);
    endtask

    task automatic check_state(input string tag, input int ev, input int eop,
                               input int eup, input int eos, input int eus,
                               input int ege);
        chk({tag, " value"},      int'(value),      ev);
        chk({tag, " ovf_pulse"},  int'(ovf_pulse),  eop);
        chk({tag, " udf_pulse"},  int'(udf_pulse),  eup);
        chk({tag, " ovf_sticky"}, int'(ovf_sticky), eos);
        chk({tag, " udf_sticky"}, int'(udf_sticky), eus);
        chk({tag, " at_zero"},    int'(at_zero),    (ev == 0) ? 1 : 0);
        chk({tag, " at_max"},     int'(at_max),     (ev == MAXV) ? 1 : 0);
        chk({tag, " ge_thresh"},  int'(ge_thresh),  ege);
    endtask

    vec_t tbl[27];

    initial begin
        // rst reinit iv inc dv dec sat clr init thr | val op up os us ge
        tbl[0]  = mk(0,0,0,0,0,0,0,0, 8,6,  8,0,0,0,0,1);  // reset load
        tbl[1]  = mk(1,0,1,3,0,0,0,0, 0,6,  1,1,0,1,0,0);  // wrap overflow 8+3
        tbl[2]  = mk(1,0,0,0,0,0,0,0, 0,6,  1,0,0,1,0,0);  // hold, pulse drops
        tbl[3]  = mk(1,1,0,0,0,0,0,0, 8,6,  8,0,0,1,0,1);  // reinit 8
        tbl[4]  = mk(1,0,1,3,0,0,1,0, 0,6,  9,1,0,1,0,1);  // sat overflow
        tbl[5]  = mk(1,1,0,0,0,0,0,0, 1,6,  1,0,0,1,0,0);  // reinit 1
        tbl[6]  = mk(1,0,0,0,1,3,0,0, 0,6,  8,0,1,1,1,1);  // wrap underflow 1-3
        tbl[7]  = mk(1,1,0,0,0,0,0,0, 1,6,  1,0,0,1,1,0);  // reinit 1
        tbl[8]  = mk(1,0,0,0,1,3,1,0, 0,6,  0,0,1,1,1,0);  // sat underflow
        tbl[9]  = mk(1,0,0,0,0,0,0,1, 0,6,  0,0,0,0,0,0);  // clear, no event
        tbl[10] = mk(1,0,1,2,1,3,0,0, 0,6,  9,0,1,0,1,1);  // 0+2-3 wraps to 9
        tbl[11] = mk(1,1,0,0,0,0,0,0, 0,6,  0,0,0,0,1,0);  // reinit 0
        tbl[12] = mk(1,0,1,3,1,3,0,0, 0,6,  0,0,0,0,1,0);  // +3-3 no event
        tbl[13] = mk(1,1,0,0,0,0,0,0, 2,6,  2,0,0,0,1,0);  // reinit 2
        tbl[14] = mk(1,1,1,1,0,0,0,0, 5,6,  6,0,0,0,1,1);  // reinit 5 +1
        tbl[15] = mk(1,1,0,0,0,0,0,0,15,6,  9,0,0,0,1,1);  // reinit clamps 15
        tbl[16] = mk(1,0,1,3,0,0,0,0, 0,6,  2,1,0,1,1,0);  // 9+3 wraps to 2
        tbl[17] = mk(1,0,1,2,0,0,0,0, 0,6,  4,0,0,1,1,0);  // value 4, sticky
        tbl[18] = mk(0,0,1,3,0,0,0,0, 7,6,  7,0,0,0,0,1);  // reset overrides
        tbl[19] = mk(1,0,1,1,0,0,0,0, 0,6,  8,0,0,0,0,1);  // counts after reset
        tbl[20] = mk(1,0,1,3,0,0,0,0, 0,6,  1,1,0,1,0,0);  // overflow 8+3
        tbl[21] = mk(1,1,1,2,0,0,0,1, 9,6,  1,1,0,1,0,0);  // clear vs new event
        tbl[22] = mk(1,0,0,0,0,0,0,1, 0,6,  1,0,0,0,0,0);  // clear wins alone
        tbl[23] = mk(1,1,0,0,0,0,0,0, 5,6,  5,0,0,0,0,0);  // threshold step 5
        tbl[24] = mk(1,0,1,1,0,0,0,0, 0,6,  6,0,0,0,0,1);  // -> 6, ge rises
        tbl[25] = mk(1,0,1,0,1,0,0,0, 0,6,  6,0,0,0,0,1);  // zero deltas
        tbl[26] = mk(1,0,0,0,0,0,0,0, 0,7,  6,0,0,0,0,0);  // threshold raised

        rst_n = 1'b0; reinit = 1'b0; initial_value = '0; incr_valid = 1'b0;
        incr = '0; decr_valid = 1'b0; decr = '0; sat_mode = 1'b0;
        clear_flags = 1'b0; threshold = '0;
        @(negedge clk);

        for (int i = 0; i < 27; i++) begin
            string tag;
            tag = $sformatf("row%0d", i);
            apply(tbl[i], tag);
            check_state(tag, tbl[i].e_val, tbl[i].e_op, tbl[i].e_up,
                        tbl[i].e_os, tbl[i].e_us, tbl[i].e_ge);
        end

        // Back-to-back saturating overflows must pulse on each cycle.
        apply(mk(1,1,1,1,0,0,1,0, 9,7, 0,0,0,0,0,0), "seq_a");
        check_state("seq_a", 9, 1, 0, 1, 0, 1);
        apply(mk(1,0,1,1,0,0,1,0, 0,7, 0,0,0,0,0,0), "seq_b");
        check_state("seq_b", 9, 1, 0, 1, 0, 1);
        apply(mk(1,0,0,0,0,0,1,0, 0,7, 0,0,0,0,0,0), "seq_c");
        check_state("seq_c", 9, 0, 0, 1, 0, 1);
        // Reinit to 0 then decrement in wrap mode: underflow from the load.
        apply(mk(1,1,0,0,1,2,0,0, 0,7, 0,0,0,0,0,0), "seq_d");
        check_state("seq_d", 8, 0, 1, 1, 1, 1);

        // Randomized run against the reference model.
        for (int i = 0; i < 600; i++) begin
            vec_t r;
            string tag;
            r = mk(($urandom_range(31) != 0) ? 1 : 0, ($urandom_range(7) == 0) ? 1 : 0,
                   int'($urandom_range(1)), int'($urandom_range(3)),
                   int'($urandom_range(1)), int'($urandom_range(3)),
                   int'($urandom_range(1)), ($urandom_range(5) == 0) ? 1 : 0,
                   int'($urandom_range(15)), int'($urandom_range(15)),
                   0,0,0,0,0,0);
            tag = $sformatf("rnd%0d", i);
            apply(r, tag);
            check_state(tag, m_val, m_ovp, m_udp, m_ovs, m_uds, m_ge);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/counter_sat.md
Name: counter_sat

Overview:
- Parametrised successor to the team's fixed 4-bit up/down counter: configurable width, delta widths and modulus, with a runtime choice between wrap and saturate.
- Per cycle it applies an optional increment and an optional decrement, in the same cycle if both are valid.
- Adds registered overflow/underflow event pulses, sticky flags with clear, a threshold compare, and a combinational look-ahead value_next.
- Used for credit, occupancy and event tracking in datapath control blocks.

Parameters:
WIDTH, 8, counter width in bits
INCR_WIDTH, 2, width of incr operand
DECR_WIDTH, 2, width of decr operand
MAX_VALUE, 2**WIDTH-1, highest legal count; wrap modulus is MAX_VALUE+1; elaboration error if MAX_VALUE > 2**WIDTH-1 or if either delta maximum exceeds MAX_VALUE+1

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
reinit  in  1  use initial_value as base operand this cycle
initial_value  in  WIDTH  reset/reinit load value
incr_valid  in  1  qualifies incr
incr  in  INCR_WIDTH  unsigned increment amount
decr_valid  in  1  qualifies decr
decr  in  DECR_WIDTH  unsigned decrement amount
sat_mode  in  1  1 = saturate at 0/MAX_VALUE, 0 = wrap modulo MAX_VALUE+1
clear_flags  in  1  clear sticky flags
threshold  in  WIDTH  compare level
value  out  WIDTH  registered count
value_next  out  WIDTH  combinational next count
ovf_pulse  out  1  registered, 1 cycle after an overflow update
udf_pulse  out  1  registered, 1 cycle after an underflow update
ovf_sticky  out  1  set by overflow, held until cleared
udf_sticky  out  1  set by underflow, held until cleared
at_zero  out  1  value == 0 (combinational from register)
at_max  out  1  value == MAX_VALUE (combinational from register)
ge_thresh  out  1  registered: value_next >= threshold, updated with value

Behaviour:
- Reset (rst_n=0 at clk edge):
  - value <= min(initial_value, MAX_VALUE).
  - All pulses, sticky flags and ge_thresh <= 0, except that ge_thresh is computed from the loaded value.
  - Reset overrides every other input.
- Base operand: base = reinit ? min(initial_value, MAX_VALUE) : value.
- Raw sum:
  - raw = base + (incr_valid ? incr : 0) - (decr_valid ? decr : 0).
  - Evaluated signed, at WIDTH+2 bits, so no intermediate truncation.
- Overflow: raw > MAX_VALUE. Underflow: raw < 0. The two are mutually exclusive by construction.
- Wrap mode (sat_mode=0):
  - Overflow: value_next = raw - (MAX_VALUE+1).
  - Underflow: value_next = raw + (MAX_VALUE+1).
  - Otherwise: value_next = raw.
- Saturate mode (sat_mode=1): overflow gives MAX_VALUE, underflow gives 0, otherwise raw.
- Hold: with no incr_valid, decr_valid or reinit, value_next = value, and no event is flagged.
- Register update: value <= value_next every cycle when rst_n=1. Latency from inputs to value is 1 cycle.
- Event pulses: ovf_pulse/udf_pulse <= overflow/underflow of this cycle. They are single-cycle and reassert on every such cycle.
- Sticky flags: sticky <= (sticky & ~clear_flags) | event. When clear_flags coincides with a new event, the flag stays 1.
- sat_mode and threshold are sampled combinationally. A mode change affects the same cycle's value_next.
- A delta of 0 with valid=1 counts as no change and raises no event.
- The reinit load itself never flags an event; only the applied deltas can.
- value_next is valid every cycle, including the cycle rst_n is low, where it shows the unreset computation. Consumers must not rely on it during reset.

Decomposition:
- Shared package counter_pkg:
  - typedef cnt_mode_e {CNT_WRAP=0, CNT_SAT=1} for sat_mode.
  - Function clog2-safe width helper.
- Sub-module counter_sat_next: purely combinational. Inputs are base, deltas and mode; outputs are value_next, ovf and udf. It is reused by the future multi-channel counter bank.
- The top holds only the registers, flags and compare.

Test Plan:
All scenarios use WIDTH=4, MAX_VALUE=9, INCR_WIDTH=DECR_WIDTH=2.
- Overflow: value=8, incr=3 valid, sat_mode=0 -> value=1 next cycle, ovf_pulse=1 for one cycle, ovf_sticky=1. Repeat with sat_mode=1 -> value=9, ovf_pulse=1.
- Underflow: value=1, decr=3 valid, sat_mode=0 -> value=8, udf_pulse=1. With sat_mode=1 -> value=0, at_zero=1, udf_sticky=1.
- Simultaneous deltas: value=0, incr=2 and decr=3 both valid, wrap -> value=9, at_max=1, udf_pulse=1. Same value with incr=3, decr=3 -> value=0, no pulse.
- Reinit: value=2, reinit=1, initial_value=5, incr=1 valid -> value=6, no event. initial_value=15 with reinit, no deltas -> value=9.
- Reset mid-run: value=4, ovf_sticky=1, then rst_n=0 for 1 cycle with initial_value=7 and incr valid -> value=7, all flags 0. Next cycle with rst_n=1 the counter counts normally.
- Flag clear race: ovf_sticky=1, clear_flags=1 with no event -> 0 next cycle. clear_flags=1 in the same cycle as a new overflow -> ovf_sticky stays 1. With threshold=6, stepping value 5 -> 6 -> ge_thresh 0 -> 1, aligned with value.
